// File: rtl/shiftx_pkg.sv
// Purpose: shared constants and helpers for the shiftx bit-field extract family.
// Latency: n/a (constant functions and a combinational per-bit extract helper).
// Backpressure: n/a.
// Contents: calc_id_w (requester id width), calc_off_w (overflow-free offset
// width), extract_bit (zero-fill single-bit pick that also flags out-of-range).
package shiftx_pkg;

  // Widest source word any shiftx consumer may present to extract_bit.
  localparam int MAX_A_W = 256;
  localparam int IDX_W   = $clog2(MAX_A_W);

  function automatic int calc_id_w(input int num_req);
    return (num_req <= 1) ? 1 : $clog2(num_req);
  endfunction

  // Two extra bits give room for the sign and for off + (Y_WIDTH-1) without wrap.
  function automatic int calc_off_w(input int b_width, input int a_width, input int y_width);
    int w;
    w = $clog2(a_width + y_width);
    return ((b_width > w) ? b_width : w) + 2;
  endfunction

  // Returns {oob, y} for a single field bit at signed source position pos.
  // Positions outside [0, a_width-1] read as 0 and raise oob.
  function automatic logic [1:0] extract_bit(input logic [MAX_A_W-1:0] a,
                                             input int pos,
                                             input int a_width);
    logic [1:0] r;
    r = 2'b10;
    if (pos >= 0 && pos < a_width) begin
      r = {1'b0, a[IDX_W'(pos)]};
    end
    return r;
  endfunction

endpackage

// File: rtl/shiftx_arbiter_if.sv
// Purpose: request/response bundle between field-decode clients and the shiftx arbiter.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready per requester, rsp_valid/rsp_ready on the result.
// Modports: master = client side (drives requests, consumes results),
//           slave  = arbiter side (grants requests, produces results).
interface shiftx_arbiter_if
  import shiftx_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 6,
  parameter int Y_WIDTH = 8
);
  localparam int ID_W = calc_id_w(NUM_REQ);

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*A_WIDTH-1:0] req_a;
  logic [NUM_REQ*B_WIDTH-1:0] req_b;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [Y_WIDTH-1:0]         rsp_y;
  logic [ID_W-1:0]            rsp_id;
  logic                       rsp_oob;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_id, rsp_oob
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_id, rsp_oob
  );

endinterface

// File: rtl/shiftx_extract.sv
// Purpose: combinational zero-fill bit-field extract, Y = A[off +: Y_WIDTH].
// Latency: 0 cycles (pure combinational).
// Backpressure: none, no handshake.
// Ports: a (source word), b (offset, signed when B_SIGNED=1), y (field), oob (any bit outside A).
module shiftx_extract
  import shiftx_pkg::*;
#(
  parameter int A_WIDTH  = 32,
  parameter int B_WIDTH  = 6,
  parameter int Y_WIDTH  = 8,
  parameter int B_SIGNED = 0
) (
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  output logic [Y_WIDTH-1:0] y,
  output logic               oob
);
  localparam int OFF_W = calc_off_w(B_WIDTH, A_WIDTH, Y_WIDTH);

  logic signed [OFF_W-1:0] off;
  logic [MAX_A_W-1:0]      a_ext;
  logic [Y_WIDTH-1:0]      oob_bits;

  if (B_SIGNED != 0) begin : g_signed
    assign off = OFF_W'(signed'(b));
  end else begin : g_unsigned
    assign off = signed'(OFF_W'(b));
  end

  assign a_ext = MAX_A_W'(a);

  always_comb begin
    y        = '0;
    oob_bits = '0;
    for (int i = 0; i < Y_WIDTH; i++) begin
      {oob_bits[i], y[i]} = extract_bit(a_ext, int'(off) + i, A_WIDTH);
    end
  end

  assign oob = |oob_bits;

endmodule

// File: rtl/shiftx_arbiter.sv
// Purpose: round-robin arbiter sharing one shiftx extract unit among NUM_REQ requesters.
// Latency: 1 cycle from request handshake to rsp_valid; 1 result/cycle sustained.
// Backpressure: rsp_ready low with a held result blocks all grants; req_ready is combinational.
// Ports: clk, rst (async, active-high), bus (slave modport: req_valid/ready/a/b, rsp_valid/ready/y/id/oob).
module shiftx_arbiter
  import shiftx_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int A_WIDTH  = 32,
  parameter int B_WIDTH  = 6,
  parameter int Y_WIDTH  = 8,
  parameter int B_SIGNED = 0
) (
  input  logic            clk,
  input  logic            rst,
  shiftx_arbiter_if.slave bus
);
  localparam int ID_W = calc_id_w(NUM_REQ);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]         state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    ptr_nxt;
  logic [ID_W-1:0]    gnt_idx;
  logic [ID_W:0]      slot;
  logic               gnt_any;
  logic               can_accept;
  logic               fire;
  logic [A_WIDTH-1:0] a_sel;
  logic [B_WIDTH-1:0] b_sel;
  logic [Y_WIDTH-1:0] y_nxt;
  logic               oob_nxt;
  logic [Y_WIDTH-1:0] y_q;
  logic [ID_W-1:0]    id_q;
  logic               oob_q;

  // A held result that is being drained this cycle frees the register.
  assign can_accept = (state == ST_EMPTY) | bus.rsp_ready;

  // First valid requester scanning upward from ptr with wrap. slot is at most
  // 2*NUM_REQ-2, so one conditional subtract is a full modulo.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    slot    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      slot = {1'b0, ptr} + (ID_W+1)'(k);
      if (slot >= (ID_W+1)'(NUM_REQ)) begin
        slot = slot - (ID_W+1)'(NUM_REQ);
      end
      if (!gnt_any && bus.req_valid[slot[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = slot[ID_W-1:0];
      end
    end
  end

  assign fire = gnt_any & can_accept & ~rst;

  always_comb begin
    bus.req_ready = '0;
    if (fire) begin
      bus.req_ready[gnt_idx] = 1'b1;
    end
  end

  assign ptr_nxt = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  assign a_sel = bus.req_a[gnt_idx*A_WIDTH +: A_WIDTH];
  assign b_sel = bus.req_b[gnt_idx*B_WIDTH +: B_WIDTH];

  shiftx_extract #(
    .A_WIDTH  (A_WIDTH),
    .B_WIDTH  (B_WIDTH),
    .Y_WIDTH  (Y_WIDTH),
    .B_SIGNED (B_SIGNED)
  ) u_extract (
    .a   (a_sel),
    .b   (b_sel),
    .y   (y_nxt),
    .oob (oob_nxt)
  );

  // Drain without refill returns to EMPTY but keeps the last payload visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
      ptr   <= '0;
      y_q   <= '0;
      id_q  <= '0;
      oob_q <= 1'b0;
    end else if (fire) begin
      state <= ST_FULL;
      ptr   <= ptr_nxt;
      y_q   <= y_nxt;
      id_q  <= gnt_idx;
      oob_q <= oob_nxt;
    end else if (bus.rsp_ready) begin
      state <= ST_EMPTY;
    end
  end

  assign bus.rsp_valid = (state == ST_FULL);
  assign bus.rsp_y     = y_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_oob   = oob_q;

endmodule

// File: tb/tb_shiftx_arbiter.sv
// Purpose: directed scoreboard bench for shiftx_arbiter (unsigned and signed-offset instances).
// Latency: expectations are queued at issue; monitors pop on every accepted result.
// Backpressure: exercised by holding rsp_ready low with all requesters valid.
module tb_shiftx_arbiter;
  import shiftx_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int A_WIDTH = 32;
  localparam int B_WIDTH = 6;
  localparam int Y_WIDTH = 8;

  typedef struct packed {
    logic [7:0] y;
    logic [1:0] id;
    logic       oob;
  } rsp_t;

  typedef struct {
    bit         en;
    int         idx;
    logic [5:0] b;
    logic [7:0] y;
    logic       oob;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  shiftx_arbiter_if #(.NUM_REQ(NUM_REQ), .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH), .Y_WIDTH(Y_WIDTH)) bus_u ();
  shiftx_arbiter_if #(.NUM_REQ(NUM_REQ), .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH), .Y_WIDTH(Y_WIDTH)) bus_s ();

  shiftx_arbiter #(.NUM_REQ(NUM_REQ), .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH), .Y_WIDTH(Y_WIDTH), .B_SIGNED(0)) dut_u (
    .clk (clk),
    .rst (rst),
    .bus (bus_u)
  );

  shiftx_arbiter #(.NUM_REQ(NUM_REQ), .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH), .Y_WIDTH(Y_WIDTH), .B_SIGNED(1)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  rsp_t exp_u[$];
  rsp_t exp_s[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: every accepted result must match the oldest expectation.
  always @(negedge clk) begin
    rsp_t e;
    if (!rst && bus_u.rsp_valid && bus_u.rsp_ready) begin
      if (exp_u.size() == 0) begin
        check("u_unexpected_rsp", 32'(bus_u.rsp_valid), 32'(0));
      end else begin
        e = exp_u.pop_front();
        check("u_rsp_y",   32'(bus_u.rsp_y),   32'(e.y));
        check("u_rsp_id",  32'(bus_u.rsp_id),  32'(e.id));
        check("u_rsp_oob", 32'(bus_u.rsp_oob), 32'(e.oob));
      end
    end
  end

  always @(negedge clk) begin
    rsp_t e;
    if (!rst && bus_s.rsp_valid && bus_s.rsp_ready) begin
      if (exp_s.size() == 0) begin
        check("s_unexpected_rsp", 32'(bus_s.rsp_valid), 32'(0));
      end else begin
        e = exp_s.pop_front();
        check("s_rsp_y",   32'(bus_s.rsp_y),   32'(e.y));
        check("s_rsp_id",  32'(bus_s.rsp_id),  32'(e.id));
        check("s_rsp_oob", 32'(bus_s.rsp_oob), 32'(e.oob));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t       vu[4];
    vec_t       vs[4];
    logic [7:0] fy[4];
    logic [3:0] exp_rdy;

    rst = 1'b1;
    bus_u.req_valid = '0; bus_u.req_a = '0; bus_u.req_b = '0; bus_u.rsp_ready = 1'b0;
    bus_s.req_valid = '0; bus_s.req_a = '0; bus_s.req_b = '0; bus_s.rsp_ready = 1'b0;

    // Reset values, and no grants while rst is high even with requests pending.
    #1;
    bus_u.req_valid = 4'hF;
    bus_u.rsp_ready = 1'b1;
    #1;
    check("rst_rsp_valid", 32'(bus_u.rsp_valid), 32'(0));
    check("rst_rsp_y",     32'(bus_u.rsp_y),     32'(0));
    check("rst_rsp_id",    32'(bus_u.rsp_id),    32'(0));
    check("rst_rsp_oob",   32'(bus_u.rsp_oob),   32'(0));
    check("rst_req_ready", 32'(bus_u.req_ready), 32'(0));
    step();
    step();
    rst = 1'b0;
    bus_u.req_valid = '0;
    bus_s.rsp_ready = 1'b1;

    // Test 1: single requester, basic extract and 1-cycle latency.
    step();
    bus_u.req_valid = 4'b0100;
    bus_u.req_a[2*A_WIDTH +: A_WIDTH] = 32'hDEADBEEF;
    bus_u.req_b[2*B_WIDTH +: B_WIDTH] = 6'd4;
    #1;
    check("t1_req_ready",        32'(bus_u.req_ready), 32'(4'b0100));
    check("t1_rsp_valid_before", 32'(bus_u.rsp_valid), 32'(0));
    exp_u.push_back('{y: 8'hEE, id: 2'd2, oob: 1'b0});
    step();
    bus_u.req_valid = '0;
    check("t1_rsp_valid_after", 32'(bus_u.rsp_valid), 32'(1));
    step();
    check("t1_drained", 32'(bus_u.rsp_valid), 32'(0));

    // Test 2: out-of-range fill, unsigned (ptr now 3) and signed (ptr 0) in parallel.
    for (int i = 0; i < NUM_REQ; i++) begin
      bus_u.req_a[i*A_WIDTH +: A_WIDTH] = 32'hDEADBEEF;
      bus_s.req_a[i*A_WIDTH +: A_WIDTH] = 32'hDEADBEEF;
    end
    vu[0] = '{1'b1, 1, 6'd28, 8'h0D, 1'b1};
    vu[1] = '{1'b1, 2, 6'd24, 8'hDE, 1'b0};
    vu[2] = '{1'b1, 3, 6'd25, 8'h6F, 1'b1};
    vu[3] = '{1'b0, 0, 6'd0,  8'h00, 1'b0};
    vs[0] = '{1'b1, 0, 6'h3C, 8'hF0, 1'b1};
    vs[1] = '{1'b1, 1, 6'h20, 8'h00, 1'b1};
    vs[2] = '{1'b1, 2, 6'h1F, 8'h01, 1'b1};
    vs[3] = '{1'b1, 3, 6'h04, 8'hEE, 1'b0};
    for (int c = 0; c < 4; c++) begin
      bus_u.req_valid = '0;
      bus_s.req_valid = '0;
      if (vu[c].en) begin
        bus_u.req_valid[vu[c].idx] = 1'b1;
        bus_u.req_b[vu[c].idx*B_WIDTH +: B_WIDTH] = vu[c].b;
        exp_u.push_back('{y: vu[c].y, id: 2'(vu[c].idx), oob: vu[c].oob});
      end
      if (vs[c].en) begin
        bus_s.req_valid[vs[c].idx] = 1'b1;
        bus_s.req_b[vs[c].idx*B_WIDTH +: B_WIDTH] = vs[c].b;
        exp_s.push_back('{y: vs[c].y, id: 2'(vs[c].idx), oob: vs[c].oob});
      end
      #1;
      exp_rdy = vu[c].en ? (4'b0001 << vu[c].idx) : 4'b0000;
      check("t2_u_req_ready", 32'(bus_u.req_ready), 32'(exp_rdy));
      exp_rdy = vs[c].en ? (4'b0001 << vs[c].idx) : 4'b0000;
      check("t2_s_req_ready", 32'(bus_s.req_ready), 32'(exp_rdy));
      step();
    end
    bus_u.req_valid = '0;
    bus_s.req_valid = '0;
    step();

    // Test 3: all valid for 8 cycles, strict rotation 0,1,2,3,0,1,2,3 with no bubble.
    fy = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    bus_u.req_a[0*A_WIDTH +: A_WIDTH] = 32'h000000A0; bus_u.req_b[0*B_WIDTH +: B_WIDTH] = 6'd0;
    bus_u.req_a[1*A_WIDTH +: A_WIDTH] = 32'h0000B100; bus_u.req_b[1*B_WIDTH +: B_WIDTH] = 6'd8;
    bus_u.req_a[2*A_WIDTH +: A_WIDTH] = 32'h00C20000; bus_u.req_b[2*B_WIDTH +: B_WIDTH] = 6'd16;
    bus_u.req_a[3*A_WIDTH +: A_WIDTH] = 32'hD3000000; bus_u.req_b[3*B_WIDTH +: B_WIDTH] = 6'd24;
    bus_u.req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      exp_u.push_back('{y: fy[k % 4], id: 2'(k % 4), oob: 1'b0});
      #1;
      check("t3_req_ready", 32'(bus_u.req_ready), 32'(4'b0001 << (k % 4)));
      if (k > 0) check("t3_no_bubble", 32'(bus_u.rsp_valid), 32'(1));
      step();
    end
    bus_u.req_valid = '0;
    step();
    check("t3_all_results_seen", 32'(exp_u.size()), 32'(0));

    // Test 4: back-pressure with all valid; nothing moves for 5 cycles.
    bus_u.req_valid = 4'hF;
    exp_u.push_back('{y: 8'hA0, id: 2'd0, oob: 1'b0});
    #1;
    check("t4_first_grant", 32'(bus_u.req_ready), 32'(4'b0001));
    step();
    bus_u.rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t4_bp_req_ready", 32'(bus_u.req_ready), 32'(0));
      check("t4_bp_rsp_valid", 32'(bus_u.rsp_valid), 32'(1));
      check("t4_bp_rsp_y",     32'(bus_u.rsp_y),     32'(8'hA0));
      check("t4_bp_rsp_id",    32'(bus_u.rsp_id),    32'(0));
      step();
    end
    bus_u.rsp_ready = 1'b1;
    exp_u.push_back('{y: 8'hB1, id: 2'd1, oob: 1'b0});
    #1;
    check("t4_release_grant", 32'(bus_u.req_ready), 32'(4'b0010));
    step();
    bus_u.req_valid = '0;
    step();
    check("t4_drained", 32'(bus_u.rsp_valid), 32'(0));

    // Test 5: async reset while a result is held discards it.
    bus_u.rsp_ready = 1'b0;
    bus_u.req_valid = 4'b0010;
    #1;
    check("t5_fill_grant", 32'(bus_u.req_ready), 32'(4'b0010));
    step();
    bus_u.req_valid = '0;
    check("t5_held", 32'(bus_u.rsp_valid), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_rsp_valid", 32'(bus_u.rsp_valid), 32'(0));
    check("t5_rst_rsp_y",     32'(bus_u.rsp_y),     32'(0));
    check("t5_rst_rsp_id",    32'(bus_u.rsp_id),    32'(0));
    bus_u.req_valid = 4'b1001;
    bus_u.rsp_ready = 1'b1;
    #1;
    check("t5_rst_req_ready", 32'(bus_u.req_ready), 32'(0));
    step();
    step();
    rst = 1'b0;
    exp_u.push_back('{y: 8'hA0, id: 2'd0, oob: 1'b0});
    #1;
    check("t5_first_grant", 32'(bus_u.req_ready), 32'(4'b0001));
    step();
    bus_u.req_valid = '0;
    step();
    step();

    check("end_u_queue_empty", 32'(exp_u.size()), 32'(0));
    check("end_s_queue_empty", 32'(exp_s.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shiftx_arbiter.md
# shiftx_arbiter

Round-robin arbiter and response pipeline that shares one bit-field extract unit among NUM_REQ requesters. Each requester presents a source word A and an offset B and receives Y = Y_WIDTH bits of A starting at bit B, with zero-fill for bits outside A. The block sits between independent field-decode clients and the single `$shiftx`-style datapath. It owns grant sequencing, the single-entry result register and the valid/ready handshakes.

## Interface
- NUM_REQ, 4: number of requesters, ≥1
- A_WIDTH, 32: source word width
- B_WIDTH, 6: offset width
- Y_WIDTH, 8: extracted field width, ≥1
- B_SIGNED, 0: 1 = offset is two's complement, 0 = unsigned
- ID_W, derived: max(1, $clog2(NUM_REQ))

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant/accept, at most one bit set
- req_a  in  NUM_REQ*A_WIDTH  packed source words, requester i at [i*A_WIDTH +: A_WIDTH]
- req_b  in  NUM_REQ*B_WIDTH  packed offsets, requester i at [i*B_WIDTH +: B_WIDTH]
- rsp_valid  out  1  result register holds a result
- rsp_ready  in  1  consumer accepts result
- rsp_y  out  Y_WIDTH  extracted field
- rsp_id  out  ID_W  index of the requester that produced rsp_y
- rsp_oob  out  1  at least one bit of rsp_y came from outside [0, A_WIDTH-1]

## Operation
- States: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- can_accept = EMPTY | (FULL & rsp_ready).
- Grant is combinational. If can_accept and any req_valid is set, req_ready[g]=1 for the first valid requester scanning from index ptr upward, modulo NUM_REQ. Otherwise req_ready is all zero.
- On a handshake at requester g:
  - the register loads rsp_y, rsp_id=g and rsp_oob from req_a[g]/req_b[g];
  - ptr ← (g+1) mod NUM_REQ;
  - the state becomes FULL.
- FULL & rsp_ready with no grant → EMPTY. Output fields hold their last values.
- FULL & !rsp_ready → every field is held stable and req_ready is all zero.
- Extraction:
  - off = B interpreted per B_SIGNED, computed at width max(B_WIDTH, $clog2(A_WIDTH+Y_WIDTH))+2 signed, so there is no overflow.
  - For i in 0..Y_WIDTH-1: Y[i] = A[off+i] if 0 ≤ off+i < A_WIDTH, else 0. There is never an X.
  - rsp_oob = OR over i of (off+i < 0 | off+i ≥ A_WIDTH).
- ptr advances only on a handshake. Idle cycles and back-pressure do not move it.
- Requesters may drop req_valid without handshaking. No request stickiness is required.

## Timing
- Reset values: rsp_valid=0, rsp_y=0, rsp_id=0, rsp_oob=0, ptr=0, state EMPTY. req_ready=0 while rst is high.
- Reset asserted mid-operation discards any held result. The first grant after reset goes to the lowest valid index.
- Latency: the handshake in cycle n produces rsp_valid=1 with the result in cycle n+1.
- Throughput: 1 result per cycle while rsp_ready stays high. Fill and drain happen in the same cycle with no bubble.
- Fairness: with all NUM_REQ requesters continuously valid, each is granted exactly once in any NUM_REQ consecutive handshakes.
- Simultaneous drain and grant in FULL: the new result replaces the old one in the same edge, and rsp_valid stays 1.
- Combinational paths are allowed:
  - req_valid → req_ready
  - rsp_ready → req_ready
- No combinational path from any input to rsp_*.

## Structure
- Package shiftx_pkg holds:
  - the ID_W derivation function;
  - the offset-width constant function;
  - the zero-fill extract function (A, off) → {oob, Y), shared with other shiftx consumers.
- Sub-module shiftx_extract is the combinational extract core, parameterised as A_WIDTH/B_WIDTH/Y_WIDTH/B_SIGNED. The arbiter instantiates it once on the muxed granted request.
- Arbiter logic (rotate, priority-pick, ptr) and the result register stay in shiftx_arbiter.

## Test plan
1. **Basic extract, latency and reset values.** Defaults, only req 2 valid, A=0xDEADBEEF, B=4, rsp_ready=1 → req_ready=4'b0100. Next cycle: rsp_y=0xEE, rsp_id=2, rsp_oob=0. All outputs are 0 immediately after reset.
2. **Out-of-range fill.** Unsigned, A=0xDEADBEEF, B=28 → rsp_y=0x0D, rsp_oob=1. Signed, B=-4 (6'h3C) → rsp_y=0xF0, rsp_oob=1.
3. **Round-robin fairness.** All 4 valid, rsp_ready=1 for 8 cycles → rsp_id sequence 0,1,2,3,0,1,2,3, one result per cycle.
4. **Back-pressure.** Hold rsp_ready=0 for 5 cycles with all valid → req_ready=0, rsp_* stable, ptr unchanged. Release → the next grant is the expected index.
5. **Reset mid-operation.** Assert rst asynchronously while rsp_valid=1 → rsp_valid drops before the next clock edge. After release with req 3 and req 0 valid, req 0 is granted first.
